// File: rtl/coin_credit_unit.sv
// Coin credit front-end for the wash controller: debounce, credit, issue, refund.
// Optional idle auto-refund is built when TIMEOUT_REFUND_EN is defined.
module coin_credit_unit #(
   parameter int unsigned PRICE_SINGLE    = 4,
   parameter int unsigned PRICE_DOUBLE    = 7,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CREDIT_W        = 8,
   parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
   input  logic                CLK,
   input  logic                Rst_n,
   input  logic                Coin_raw,
   input  logic [1:0]          Coin_value,
   input  logic                Double_req,
   input  logic                Cancel,
   input  logic                Wash_done,
   output logic                Coin_in,
   output logic                Double_wash,
   output logic                Refund_pulse,
   output logic [CREDIT_W-1:0] Refund_amount,
   output logic [CREDIT_W-1:0] Credit,
   output logic                Busy
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYCLES);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   localparam logic [CREDIT_W-1:0] P_S = CREDIT_W'(PRICE_SINGLE);
   localparam logic [CREDIT_W-1:0] P_D = CREDIT_W'(PRICE_DOUBLE);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      ISSUE,
      WASHING,
      REFUND
   } state_t;

   state_t              state_q;
   logic                sync1_q;
   logic                sync2_q;
   logic [DBW-1:0]      db_cnt_q;
   logic                wd_q;
   logic [CREDIT_W-1:0] credit_q;
   logic                coin_in_q;
   logic                dbl_q;
   logic                refund_q;
   logic [CREDIT_W-1:0] refund_amt_q;
   logic                busy_q;

   logic                accept;
   logic [CREDIT_W-1:0] coin_amt;
   logic [CREDIT_W:0]   credit_sum;
   logic [CREDIT_W-1:0] credit_add;
   logic [31:0]         price_sel;
   logic                price_met;
   logic [CREDIT_W-1:0] issue_price;
   logic                wd_rise;
   logic                tmo_hit;
   logic                do_refund;

   // Synchronise the coin sensor, debounce it, and register Wash_done for edges
   always_ff @(posedge CLK) begin
      if (!Rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_cnt_q <= '0;
         wd_q     <= 1'b0;
      end else begin
         sync1_q <= Coin_raw;
         sync2_q <= sync1_q;
         wd_q    <= Wash_done;
         if (!sync2_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q != DB_MAX) begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
      end
   end

   // A coin is taken only on the cycle the counter climbs onto its limit
   assign accept = sync2_q && (db_cnt_q == DB_LAST);

   // Denomination decode of the sampled value code
   always_comb begin
      coin_amt = '0;
      case (Coin_value)
         2'b00:   coin_amt = CREDIT_W'(1);
         2'b01:   coin_amt = CREDIT_W'(2);
         2'b10:   coin_amt = CREDIT_W'(5);
         default: coin_amt = CREDIT_W'(10);
      endcase
   end

   // Saturating credit add; the carry bit flags overflow
   always_comb begin
      credit_sum = {1'b0, credit_q};
      if (accept) begin
         credit_sum = {1'b0, credit_q} + {1'b0, coin_amt};
      end
      credit_add = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];
   end

   assign price_sel   = Double_req ? 32'(PRICE_DOUBLE) : 32'(PRICE_SINGLE);
   assign price_met   = 32'(credit_add) >= price_sel;
   assign issue_price = dbl_q ? P_D : P_S;
   assign wd_rise     = Wash_done && !wd_q;

`ifdef TIMEOUT_REFUND_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt_q;

   assign tmo_hit = (state_q == COLLECT) && !accept &&
                    (tmo_cnt_q == TMO_LAST);

   // Idle timer in COLLECT; any new coin restarts it
   always_ff @(posedge CLK) begin
      if (!Rst_n) begin
         tmo_cnt_q <= '0;
      end else if (state_q != COLLECT || accept) begin
         tmo_cnt_q <= '0;
      end else if (!tmo_hit) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   assign tmo_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

   assign do_refund = (Cancel || tmo_hit) && (credit_add != '0);

   // Main controller: state, credit balance and all registered outputs
   always_ff @(posedge CLK) begin
      if (!Rst_n) begin
         state_q      <= IDLE;
         credit_q     <= '0;
         coin_in_q    <= 1'b0;
         dbl_q        <= 1'b0;
         refund_q     <= 1'b0;
         refund_amt_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         coin_in_q    <= 1'b0;
         refund_q     <= 1'b0;
         refund_amt_q <= '0;
         unique case (state_q)
            IDLE: begin
               credit_q <= credit_add;
               if (accept || credit_q != '0) begin
                  state_q <= COLLECT;
               end
            end
            COLLECT: begin
               if (do_refund) begin
                  credit_q     <= '0;
                  refund_q     <= 1'b1;
                  refund_amt_q <= credit_add;
                  state_q      <= REFUND;
               end else if (price_met) begin
                  credit_q  <= credit_add;
                  coin_in_q <= 1'b1;
                  dbl_q     <= Double_req;
                  busy_q    <= 1'b1;
                  state_q   <= ISSUE;
               end else begin
                  credit_q <= credit_add;
               end
            end
            ISSUE: begin
               credit_q <= credit_add - issue_price;
               state_q  <= WASHING;
            end
            WASHING: begin
               credit_q <= credit_add;
               if (wd_rise) begin
                  dbl_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= (credit_add != '0) ? COLLECT : IDLE;
               end
            end
            REFUND: begin
               credit_q <= credit_add;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Coin_in       = coin_in_q;
   assign Double_wash   = dbl_q;
   assign Refund_pulse  = refund_q;
   assign Refund_amount = refund_amt_q;
   assign Credit        = credit_q;
   assign Busy          = busy_q;

endmodule

// File: doc/coin_credit_unit.md
Name: coin_credit_unit

Overview:
Payment front-end that sits directly upstream of the washing-machine controller and drives its Coin_in and Double_wash inputs. Debounces the raw coin-sensor pulse, decodes denomination, accumulates credit and fires a one-cycle Coin_in start pulse once the selected programme price is covered. Holds Double_wash stable for the whole wash, re-arms on the controller's Wash_done, and handles cancel/refund.

Parameters:
PRICE_SINGLE, 4, credit units for a single wash
PRICE_DOUBLE, 7, credit units for a double wash
DEBOUNCE_CYCLES, 4, consecutive stable-high cycles required to accept a coin (min 1)
CREDIT_W, 8, credit register width
TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (used only with TIMEOUT_REFUND_EN)

Ports:
CLK  input  1  system clock
Rst_n  input  1  synchronous reset, active-low
Coin_raw  input  1  raw coin-sensor level, asynchronous to CLK
Coin_value  input  2  denomination code, valid while Coin_raw high: 00=1, 01=2, 10=5, 11=10 units
Double_req  input  1  user programme select: 1 = double wash
Cancel  input  1  user cancel/refund request, level
Wash_done  input  1  from controller; high when wash completed
Coin_in  output  1  one-cycle start pulse to controller
Double_wash  output  1  programme select to controller, held through wash
Refund_pulse  output  1  one-cycle refund strobe
Refund_amount  output  CREDIT_W  amount to return; valid when Refund_pulse=1, else 0
Credit  output  CREDIT_W  current credit balance
Busy  output  1  high in ISSUE and WASHING

Behaviour:
- Reset (Rst_n=0 at CLK edge): state IDLE; all outputs 0; credit 0; debounce counter 0; Wash_done edge register 0.
- Coin_raw passes a 2-flop synchroniser. Debounce counter increments while synced level is high, clears when low, saturates at DEBOUNCE_CYCLES. Coin accepted exactly once, in the cycle the counter reaches DEBOUNCE_CYCLES; Coin_value is sampled in that cycle. Minimum latency Coin_raw rise -> Credit update = 2 + DEBOUNCE_CYCLES cycles.
- Credit add saturates at 2^CREDIT_W-1; never wraps.
- States: IDLE, COLLECT, ISSUE, WASHING, REFUND.
- IDLE: accepted coin -> add, go COLLECT.
- COLLECT: accepted coins add. Price = Double_req ? PRICE_DOUBLE : PRICE_SINGLE, evaluated every cycle using post-add credit. Credit >= price -> ISSUE; latch Double_wash <= Double_req. Cancel=1 with credit>0 -> REFUND; Cancel has priority over a same-cycle price match.
- ISSUE (1 cycle): Coin_in=1; credit -= latched price (surplus kept as change); -> WASHING.
- WASHING: Double_wash held; Double_req and Cancel ignored; coins still accepted and added, no issue. Rising edge of Wash_done (registered compare) -> Double_wash=0; next state COLLECT if credit>0, else IDLE. Wash_done already high on WASHING entry does not count as an edge.
- REFUND (1 cycle): Refund_pulse=1, Refund_amount=credit, credit cleared, -> IDLE. A coin accepted in this cycle is retained as new credit (IDLE -> COLLECT path applies next cycle).
- Cancel in IDLE or with zero credit: no effect.
- Reset mid-wash returns to IDLE with credit lost; no Refund_pulse.
- Coin_in is never high two consecutive cycles and never high outside ISSUE.

Optional Feature:
TIMEOUT_REFUND_EN: when defined, a counter in COLLECT clears on each accepted coin and increments otherwise; on reaching TIMEOUT_CYCLES it forces REFUND exactly as Cancel does. Counter held at 0 outside COLLECT. When undefined, the counter and logic are absent and credit persists in COLLECT indefinitely.

Test Plan:
- Reset, then coins 2+2 (Coin_value=01 twice), Double_req=0 -> Credit 2 then 4, Coin_in single pulse, Double_wash=0, Credit 0, Busy=1.
- Double_req=1, coins 5+5 -> ISSUE at Credit 10, Double_wash=1 until Wash_done rises, Credit 3 after issue, then COLLECT with Credit 3.
- Coin_raw glitch high for DEBOUNCE_CYCLES-1 cycles -> no credit change; held high 20 cycles -> exactly one coin credited.
- Coin 2, Cancel=1 -> Refund_pulse one cycle, Refund_amount=2, Credit 0, state IDLE; Cancel during WASHING -> no refund.
- 30 coins of value 10 with PRICE_SINGLE set above 255 -> Credit saturates at 255, no Coin_in.
- With TIMEOUT_REFUND_EN, TIMEOUT_CYCLES=50: coin 1 then idle -> Refund_pulse with Refund_amount=1 after 50 cycles; without macro Credit stays 1.
